// File: rtl/ddr4_v2_2_20_axi_pkg.sv
// Shared definitions for the AXI upsizer read return path: unpacker state
// encoding, AXI response codes and the width-ratio helper.
package ddr4_v2_2_20_axi_pkg;

   // Unpacker control states
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } unpack_state_e;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // log2 of the MI/SI width ratio (ratio is a power of two, at least 2)
   function automatic int ratio_log2(input int m_width, input int s_width);
      int ratio;
      int o;
      ratio = m_width / s_width;
      o     = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < ratio) begin
            o = i + 1;
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/ddr4_v2_2_20_r_unpacker_if.sv
// Bundle of the unpacker's command, MI read and SI read channels.
// slave  : the unpacker's view.
// master : the surrounding address path / controller / SI master view.
interface ddr4_v2_2_20_r_unpacker_if
   import ddr4_v2_2_20_axi_pkg::*;
#(
   parameter int C_S_DATA_WIDTH = 32,
   parameter int C_M_DATA_WIDTH = 128,
   parameter int C_ID_WIDTH     = 4
);
   localparam int O = ratio_log2(C_M_DATA_WIDTH, C_S_DATA_WIDTH);

   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [O-1:0]              cmd_offset;
   logic [7:0]                cmd_len;
   logic                      cmd_wrap;
   logic [O-1:0]              cmd_wrap_mask;
   logic [C_ID_WIDTH-1:0]     cmd_id;

   logic [C_M_DATA_WIDTH-1:0] m_rdata;
   logic [1:0]                m_rresp;
   logic                      m_rvalid;
   logic                      m_rready;

   logic [C_ID_WIDTH-1:0]     s_rid;
   logic [C_S_DATA_WIDTH-1:0] s_rdata;
   logic [1:0]                s_rresp;
   logic                      s_rlast;
   logic                      s_rvalid;
   logic                      s_rready;

   modport slave (
      input  cmd_valid, cmd_offset, cmd_len, cmd_wrap, cmd_wrap_mask, cmd_id,
      output cmd_ready,
      input  m_rdata, m_rresp, m_rvalid,
      output m_rready,
      output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
      input  s_rready
   );

   modport master (
      output cmd_valid, cmd_offset, cmd_len, cmd_wrap, cmd_wrap_mask, cmd_id,
      input  cmd_ready,
      output m_rdata, m_rresp, m_rvalid,
      input  m_rready,
      input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
      output s_rready
   );

endinterface

// File: rtl/ddr4_v2_2_20_r_unpack_oreg.sv
// Two-entry skid register. Both ready and valid come straight from
// registers, cutting every combinational path between its two sides while
// still sustaining one transfer per cycle.
module ddr4_v2_2_20_r_unpack_oreg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   logic [WIDTH-1:0] mem_r [2];
   logic             wr_ptr_r;
   logic             rd_ptr_r;
   logic [1:0]       count_r;
   logic             push_s;
   logic             pop_s;

   assign in_ready  = (count_r != 2'd2);
   assign out_valid = (count_r != 2'd0);
   assign out_data  = mem_r[rd_ptr_r];
   assign push_s    = in_valid & in_ready;
   assign pop_s     = out_valid & out_ready;

   // Entry storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r[0] <= '0;
         mem_r[1] <= '0;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/ddr4_v2_2_20_r_unpacker.sv
// Read-data unpacker: splits wide MI read beats into narrow SI beats under
// control of a per-burst command (start slice, length, in-word wrap).
// Optional macro DDR4_V2_2_R_UNPACK_OREG_EN inserts a two-entry skid
// register on the SI side (one cycle latency, no input-to-output paths).
module ddr4_v2_2_20_r_unpacker
   import ddr4_v2_2_20_axi_pkg::*;
#(
   parameter     C_FAMILY       = "virtex6",
   parameter int C_S_DATA_WIDTH = 32,
   parameter int C_M_DATA_WIDTH = 128,
   parameter int C_ID_WIDTH     = 4
) (
   input  logic ACLK,
   input  logic ARESETN,
   ddr4_v2_2_20_r_unpacker_if.slave bus
);
   localparam int           O        = ratio_log2(C_M_DATA_WIDTH, C_S_DATA_WIDTH);
   localparam logic [O-1:0] OFF_LAST = '1;

   // Family only selects nothing here; kept for parameter compatibility
   if (C_FAMILY == "") begin : g_family_unset
   end

   unpack_state_e             state_r;
   logic [O-1:0]              off_r;
   logic [O-1:0]              mask_r;
   logic [7:0]                cnt_r;
   logic                      wrap_r;
   logic [C_ID_WIDTH-1:0]     id_r;
   logic                      init_r;

   logic                      active_s;
   logic                      last_s;
   logic                      core_valid_s;
   logic                      core_ready_s;
   logic [C_S_DATA_WIDTH-1:0] core_data_s;
   logic [1:0]                core_resp_s;
   logic [C_ID_WIDTH-1:0]     core_id_s;
   logic                      core_last_s;
   logic                      beat_acc_s;
   logic                      pop_s;
   logic                      cmd_ready_s;
   logic                      load_s;
   logic [O-1:0]              off_next_s;

   // Slice selection, handshakes and next slice index
   always_comb begin
      active_s     = (state_r == ACTIVE);
      last_s       = (cnt_r == 8'd0);
      core_valid_s = active_s & bus.m_rvalid;
      if (active_s) begin
         core_data_s = bus.m_rdata[int'(off_r) * C_S_DATA_WIDTH +: C_S_DATA_WIDTH];
         core_resp_s = bus.m_rresp;
         core_id_s   = id_r;
         core_last_s = last_s;
      end else begin
         core_data_s = '0;
         core_resp_s = RESP_OKAY;
         core_id_s   = '0;
         core_last_s = 1'b0;
      end
      beat_acc_s  = core_valid_s & core_ready_s;
      // A wrap burst never leaves its wide word, so it only pops on its last beat
      pop_s       = active_s & core_ready_s & (last_s | (~wrap_r & (off_r == OFF_LAST)));
      // Ready while idle, and on the last beat so back-to-back bursts have no bubble
      cmd_ready_s = init_r & (~active_s | (beat_acc_s & last_s));
      load_s      = bus.cmd_valid & cmd_ready_s;
      if (wrap_r) begin
         off_next_s = (off_r & ~mask_r) | ((off_r + {{(O-1){1'b0}}, 1'b1}) & mask_r);
      end else begin
         off_next_s = off_r + {{(O-1){1'b0}}, 1'b1};
      end
   end

   assign bus.cmd_ready = cmd_ready_s;
   assign bus.m_rready  = pop_s;

   // Burst control FSM: command load, beat count and slice pointer
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_r <= IDLE;
         off_r   <= '0;
         mask_r  <= '0;
         cnt_r   <= 8'd0;
         wrap_r  <= 1'b0;
         id_r    <= '0;
         init_r  <= 1'b0;
      end else begin
         init_r <= 1'b1;
         case (state_r)
            IDLE: begin
               if (load_s) begin
                  off_r   <= bus.cmd_offset;
                  mask_r  <= bus.cmd_wrap_mask;
                  cnt_r   <= bus.cmd_len;
                  wrap_r  <= bus.cmd_wrap;
                  id_r    <= bus.cmd_id;
                  state_r <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (load_s) begin
                  off_r   <= bus.cmd_offset;
                  mask_r  <= bus.cmd_wrap_mask;
                  cnt_r   <= bus.cmd_len;
                  wrap_r  <= bus.cmd_wrap;
                  id_r    <= bus.cmd_id;
               end else if (beat_acc_s) begin
                  if (last_s) begin
                     state_r <= IDLE;
                  end else begin
                     cnt_r <= cnt_r - 8'd1;
                     off_r <= off_next_s;
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

`ifdef DDR4_V2_2_R_UNPACK_OREG_EN
   localparam int OW = C_ID_WIDTH + 3 + C_S_DATA_WIDTH;
   logic [OW-1:0] oreg_out_s;

   ddr4_v2_2_20_r_unpack_oreg #(
      .WIDTH (OW)
   ) u_oreg (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .in_valid  (core_valid_s),
      .in_ready  (core_ready_s),
      .in_data   ({core_id_s, core_resp_s, core_last_s, core_data_s}),
      .out_valid (bus.s_rvalid),
      .out_ready (bus.s_rready),
      .out_data  (oreg_out_s)
   );

   assign {bus.s_rid, bus.s_rresp, bus.s_rlast, bus.s_rdata} = oreg_out_s;
`else
   assign core_ready_s = bus.s_rready;
   assign bus.s_rvalid = core_valid_s;
   assign bus.s_rdata  = core_data_s;
   assign bus.s_rresp  = core_resp_s;
   assign bus.s_rid    = core_id_s;
   assign bus.s_rlast  = core_last_s;
`endif

endmodule

// File: tb/tb_ddr4_v2_2_20_r_unpacker.sv
// Scoreboard bench for the read unpacker (R=4, S=32, M=128). Commands push
// their wide words onto an MI queue and their expected narrow beats onto a
// scoreboard; a monitor pops and compares on every accepted SI beat.
module tb_ddr4_v2_2_20_r_unpacker;
   import ddr4_v2_2_20_axi_pkg::*;

   localparam int S   = 32;
   localparam int M   = 128;
   localparam int IDW = 4;
   localparam int R   = 4;
   localparam int O   = 2;

   typedef struct {
      logic [S-1:0]   data;
      logic [1:0]     resp;
      logic [IDW-1:0] id;
      logic           last;
      logic           pop;
   } beat_t;

   typedef struct {
      logic [M-1:0] data;
      logic [1:0]   resp;
   } word_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   ddr4_v2_2_20_r_unpacker_if #(
      .C_S_DATA_WIDTH (S),
      .C_M_DATA_WIDTH (M),
      .C_ID_WIDTH     (IDW)
   ) bus ();

   ddr4_v2_2_20_r_unpacker #(
      .C_FAMILY       ("virtex6"),
      .C_S_DATA_WIDTH (S),
      .C_M_DATA_WIDTH (M),
      .C_ID_WIDTH     (IDW)
   ) dut (
      .ACLK    (clk),
      .ARESETN (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   beat_t sb_q[$];
   word_t mi_q[$];
   int    beat_cyc[$];
   int    checks      = 0;
   int    failures    = 0;
   int    cyc         = 0;
   int    beat_total  = 0;
   int    rr_mode     = 0;
   logic  mi_pop_pend = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: beats and pops of one burst from the address-path rules
   task automatic issue(input int off, input int len, input bit wrap, input int mask, input int id);
      word_t        words[$];
      word_t        wd;
      beat_t        e;
      logic [M-1:0] tmp;
      int           nwords, slice, word, t;
      nwords = wrap ? 1 : ((off + len) / R + 1);
      for (int k = 0; k < nwords; k++) begin
         wd.data = {$urandom, $urandom, $urandom, $urandom};
         wd.resp = ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY;
         words.push_back(wd);
         mi_q.push_back(wd);
      end
      for (int i = 0; i <= len; i++) begin
         if (wrap) begin
            slice = (off & ~mask) | ((off + i) & mask);
            word  = 0;
            e.pop = (i == len);
         end else begin
            slice = (off + i) % R;
            word  = (off + i) / R;
            e.pop = (i == len) || (slice == R - 1);
         end
         tmp    = words[word].data;
         e.data = tmp[slice*S +: S];
         e.resp = words[word].resp;
         e.id   = IDW'(id);
         e.last = (i == len);
         sb_q.push_back(e);
      end
      bus.cmd_valid     = 1'b1;
      bus.cmd_offset    = O'(off);
      bus.cmd_len       = 8'(len);
      bus.cmd_wrap      = wrap;
      bus.cmd_wrap_mask = O'(mask);
      bus.cmd_id        = IDW'(id);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.cmd_ready && t < 200);
      check("cmd_accept", bus.cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || mi_q.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drain_sb", sb_q.size(), 0);
      check("drain_mi", mi_q.size(), 0);
      repeat (3) @(negedge clk);
      check("idle_svalid", bus.s_rvalid, 1'b0);
      check("idle_cmd_ready", bus.cmd_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   // SI monitor: scoreboard compare, stall stability, MI pop detection
   initial begin
      beat_t          e;
      logic           prev_stall = 1'b0;
      logic [S-1:0]   prev_data;
      logic           prev_last;
      logic [IDW-1:0] prev_id;
      logic [1:0]     prev_resp;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (prev_stall) begin
               check("hold_valid", bus.s_rvalid, 1'b1);
               check("hold_data", bus.s_rdata, prev_data);
               check("hold_last", bus.s_rlast, prev_last);
               check("hold_id", bus.s_rid, prev_id);
               check("hold_resp", bus.s_rresp, prev_resp);
            end
`ifndef DDR4_V2_2_R_UNPACK_OREG_EN
            if (bus.s_rvalid && !bus.s_rready) begin
               check("no_pop_stalled", bus.m_rready, 1'b0);
            end
`endif
            if (bus.s_rvalid && bus.s_rready) begin
               beat_total++;
               beat_cyc.push_back(cyc);
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat data=%0h", bus.s_rdata);
               end else begin
                  e = sb_q.pop_front();
                  check("s_rdata", bus.s_rdata, e.data);
                  check("s_rresp", bus.s_rresp, e.resp);
                  check("s_rid", bus.s_rid, e.id);
                  check("s_rlast", bus.s_rlast, e.last);
`ifndef DDR4_V2_2_R_UNPACK_OREG_EN
                  check("pop_with_beat", bus.m_rready, e.pop);
                  if (e.last) begin
                     check("cmd_ready_on_last", bus.cmd_ready, 1'b1);
                  end
`endif
               end
            end
            if (bus.m_rvalid && bus.m_rready) begin
               mi_pop_pend = 1'b1;
            end
            prev_stall = bus.s_rvalid & ~bus.s_rready;
            prev_data  = bus.s_rdata;
            prev_last  = bus.s_rlast;
            prev_id    = bus.s_rid;
            prev_resp  = bus.s_rresp;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   // MI driver: presents the head of the wide-word queue, pops after a handshake
   initial begin
      bus.m_rvalid = 1'b0;
      bus.m_rdata  = '0;
      bus.m_rresp  = 2'b00;
      forever begin
         @(posedge clk);
         #2;
         if (mi_pop_pend && mi_q.size() > 0) begin
            void'(mi_q.pop_front());
         end
         mi_pop_pend = 1'b0;
         if (mi_q.size() > 0) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = mi_q[0].data;
            bus.m_rresp  = mi_q[0].resp;
         end else begin
            bus.m_rvalid = 1'b0;
            bus.m_rdata  = '0;
            bus.m_rresp  = 2'b00;
         end
      end
   end

   // SI ready driver: 0 = always ready, 1 = toggle, 2 = random
   initial begin
      bus.s_rready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            1:       bus.s_rready = ~bus.s_rready;
            2:       bus.s_rready = ($urandom_range(0, 3) != 0);
            default: bus.s_rready = 1'b1;
         endcase
      end
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Directed tests followed by randomized bursts
   initial begin
      int t, start, off, len, wl;
      bit wrap;
      bus.cmd_valid     = 1'b0;
      bus.cmd_offset    = '0;
      bus.cmd_len       = 8'd0;
      bus.cmd_wrap      = 1'b0;
      bus.cmd_wrap_mask = '0;
      bus.cmd_id        = '0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", bus.cmd_ready, 1'b0);
      check("rst_svalid", bus.s_rvalid, 1'b0);
      check("rst_mready", bus.m_rready, 1'b0);
      check("rst_slast", bus.s_rlast, 1'b0);
      check("rst_sdata", bus.s_rdata, '0);
      check("rst_sid", bus.s_rid, '0);
      check("rst_sresp", bus.s_rresp, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_cmd_ready_low", bus.cmd_ready, 1'b0);
      @(negedge clk);
      check("rel_cmd_ready_high", bus.cmd_ready, 1'b1);
      @(posedge clk);
      #1;

      // Test 1: INCR offset 1, len 5, full throughput
      rr_mode = 0;
      beat_cyc.delete();
      issue(1, 5, 1'b0, 0, 3);
      drain();
      check("t1_beats", beat_cyc.size(), 6);
      if (beat_cyc.size() == 6) check("t1_back_to_back", beat_cyc[5] - beat_cyc[0], 5);

      // Test 2: WRAP offset 2, len 3, mask 3
      issue(2, 3, 1'b1, 3, 5);
      drain();

      // Test 3: three queued commands, no bubbles
      beat_cyc.delete();
      issue(0, 0, 1'b0, 0, 1);
      issue(2, 3, 1'b0, 0, 2);
      issue(3, 1, 1'b0, 0, 4);
      drain();
      check("t3_beats", beat_cyc.size(), 7);
      if (beat_cyc.size() == 7) check("t3_back_to_back", beat_cyc[6] - beat_cyc[0], 6);

      // Test 4: test 1 with toggling SI ready
      rr_mode = 1;
      issue(1, 5, 1'b0, 0, 6);
      drain();
      rr_mode = 0;

      // Test 5: reset in the middle of a burst
      start = beat_total;
      issue(1, 5, 1'b0, 0, 7);
      t = 0;
      while (beat_total < start + 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("t5_two_beats", beat_total - start, 2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      mi_q.delete();
      sb_q.delete();
      mi_pop_pend = 1'b0;
      #1;
      check("t5_rst_svalid", bus.s_rvalid, 1'b0);
      check("t5_rst_mready", bus.m_rready, 1'b0);
      check("t5_rst_cmd_ready", bus.cmd_ready, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_rel_cmd_ready", bus.cmd_ready, 1'b0);
      @(posedge clk);
      #1;
      issue(3, 0, 1'b0, 0, 9);
      drain();

      // Randomized bursts with random SI back-pressure
      rr_mode = 2;
      for (int n = 0; n < 40; n++) begin
         wrap = ($urandom_range(0, 2) == 0);
         off  = $urandom_range(0, R - 1);
         if (wrap) begin
            wl  = ($urandom_range(0, 1) == 0) ? 2 : 4;
            len = wl - 1;
            issue(off, len, 1'b1, wl - 1, $urandom_range(0, 15));
         end else begin
            len = $urandom_range(0, 12);
            issue(off, len, 1'b0, 0, $urandom_range(0, 15));
         end
      end
      drain();
      rr_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
